// File: rtl/uart_cmd_pkg.sv
// Shared types and widths for the UART command link.
//   CMD_W      : assembled command width (three bytes)
//   BYTE_W     : UART byte width
//   rx_state_t : command assembly states (next byte expected, or command held)
//   tx_state_t : response transmit states
package uart_cmd_pkg;

  localparam int unsigned CMD_W  = 24;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    RX_B2,
    RX_B1,
    RX_B0,
    RX_FULL
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_t;

endpackage

// File: rtl/uart_cmd_link_if.sv
// Handshake bundle between the UART byte engines, the command processor and
// the command link.
//   master : the link's view (drives clr_rx_rdy, trmt, tx_data, cmd, cmd_rdy,
//            resp_sent; receives everything else)
//   slave  : the surrounding UART / command-processor view
interface uart_cmd_link_if;
  import uart_cmd_pkg::*;

  // UART receiver side
  logic              rx_rdy;
  logic [BYTE_W-1:0] rx_data;
  logic              clr_rx_rdy;
  // UART transmitter side
  logic              trmt;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_done;
  // Command processor side
  logic [CMD_W-1:0]  cmd;
  logic              cmd_rdy;
  logic              clr_cmd_rdy;
  logic              send_resp;
  logic [BYTE_W-1:0] resp_data;
  logic              resp_sent;

  modport master (
    input  rx_rdy, rx_data, tx_done, clr_cmd_rdy, send_resp, resp_data,
    output clr_rx_rdy, trmt, tx_data, cmd, cmd_rdy, resp_sent
  );

  modport slave (
    output rx_rdy, rx_data, tx_done, clr_cmd_rdy, send_resp, resp_data,
    input  clr_rx_rdy, trmt, tx_data, cmd, cmd_rdy, resp_sent
  );

endinterface

// File: rtl/uart_cmd_link_resp_tx_seq.sv
// Response transmit sequencer: latches a response byte, fires a one-cycle
// trmt to the UART transmitter, then waits for tx_done and reports resp_sent.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   send_resp/resp_data : one-cycle request with the byte to send
//   tx_done             : UART transmitter finished the byte
//   trmt/tx_data        : start pulse and byte held until tx_done
//   resp_sent           : one-cycle completion pulse
module resp_tx_seq
  import uart_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send_resp,
  input  logic [BYTE_W-1:0] resp_data,
  input  logic              tx_done,
  output logic              trmt,
  output logic [BYTE_W-1:0] tx_data,
  output logic              resp_sent
);

  tx_state_t         tx_q, tx_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              trmt_q, trmt_d;
  logic              sent_q, sent_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q      <= TX_IDLE;
      tx_data_q <= '0;
      trmt_q    <= 1'b0;
      sent_q    <= 1'b0;
    end else begin
      tx_q      <= tx_d;
      tx_data_q <= tx_data_d;
      trmt_q    <= trmt_d;
      sent_q    <= sent_d;
    end
  end

  // Next state; requests while busy and stray tx_done while idle are dropped
  always_comb begin
    tx_d      = tx_q;
    tx_data_d = tx_data_q;
    trmt_d    = 1'b0;
    sent_d    = 1'b0;
    case (tx_q)
      TX_IDLE: begin
        if (send_resp) begin
          tx_data_d = resp_data;
          trmt_d    = 1'b1;
          tx_d      = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          sent_d = 1'b1;
          tx_d   = TX_IDLE;
        end
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  assign trmt      = trmt_q;
  assign tx_data   = tx_data_q;
  assign resp_sent = sent_q;

endmodule

// File: rtl/uart_cmd_link.sv
// UART command link: assembles three received bytes (MSB first) into a
// 24-bit command held until the command processor clears it, and forwards
// single-byte responses to the UART transmitter.
// Build option: define CMD_TIMEOUT_EN to drop a partial command after
// TIMEOUT_CYC idle cycles between bytes (TIMEOUT_CYC exists only then).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : uart_cmd_link_if.master (rx/tx handshakes, cmd, responses);
//                clr_rx_rdy is combinational, all other outputs registered
module uart_cmd_link
`ifdef CMD_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYC = 1000000)
`endif
(
  input  logic            clk,
  input  logic            rst_n,
  uart_cmd_link_if.master bus
);
  import uart_cmd_pkg::*;

  rx_state_t        rx_q, rx_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             accept_c;
  logic             timeout_c;

  // A byte is taken whenever one is pending and no command is being held
  assign accept_c       = bus.rx_rdy && (rx_q != RX_FULL);
  assign bus.clr_rx_rdy = accept_c;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            partial_c;

  assign partial_c = (rx_q == RX_B1) || (rx_q == RX_B0);
  assign timeout_c = partial_c && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  // Inter-byte idle counter, restarted by every accepted byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (accept_c || !partial_c || timeout_c) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // State and command registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q      <= RX_B2;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      rx_q      <= rx_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  // Next state; an accepted byte outranks a coincident timeout
  always_comb begin
    rx_d      = rx_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    case (rx_q)
      RX_B2: begin
        if (accept_c) begin
          cmd_d[2*BYTE_W +: BYTE_W] = bus.rx_data;
          rx_d = RX_B1;
        end
      end
      RX_B1: begin
        if (accept_c) begin
          cmd_d[BYTE_W +: BYTE_W] = bus.rx_data;
          rx_d = RX_B0;
        end else if (timeout_c) begin
          rx_d = RX_B2;
        end
      end
      RX_B0: begin
        if (accept_c) begin
          cmd_d[0 +: BYTE_W] = bus.rx_data;
          cmd_rdy_d = 1'b1;
          rx_d      = RX_FULL;
        end else if (timeout_c) begin
          rx_d = RX_B2;
        end
      end
      RX_FULL: begin
        if (bus.clr_cmd_rdy) begin
          cmd_rdy_d = 1'b0;
          rx_d      = RX_B2;
        end
      end
      default: rx_d = RX_B2;
    endcase
  end

  assign bus.cmd     = cmd_q;
  assign bus.cmd_rdy = cmd_rdy_q;

  // Response path runs independently of command assembly
  resp_tx_seq u_resp_tx_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .send_resp (bus.send_resp),
    .resp_data (bus.resp_data),
    .tx_done   (bus.tx_done),
    .trmt      (bus.trmt),
    .tx_data   (bus.tx_data),
    .resp_sent (bus.resp_sent)
  );

endmodule

// File: tb/tb_uart_cmd_link.sv
// Self-checking bench for uart_cmd_link: expected commands and response
// bytes are queued as stimulus is driven and popped when cmd_rdy rises or
// trmt fires. Build with CMD_TIMEOUT_EN to cover the inter-byte timeout.
module tb_uart_cmd_link;
  import uart_cmd_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_link_if bus();

`ifdef CMD_TIMEOUT_EN
  uart_cmd_link #(.TIMEOUT_CYC(100)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
  uart_cmd_link dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [CMD_W-1:0]  cmd_exp_q[$];
  logic [BYTE_W-1:0] tx_exp_q[$];
  logic [CMD_W-1:0]  exp_cmd;
  logic [BYTE_W-1:0] exp_tx;

  int unsigned clr_cnt  = 0;
  int unsigned trmt_cnt = 0;
  int unsigned sent_cnt = 0;
  logic        rdy_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: samples mid low phase, after drivers and logic have settled
  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      rdy_prev = 1'b0;
    end else begin
      if (bus.clr_rx_rdy) clr_cnt++;
      if (bus.cmd_rdy && !rdy_prev) begin
        if (cmd_exp_q.size() == 0) begin
          check_eq("cmd_unexpected", 32'(cmd_exp_q.size()), 32'd1);
        end else begin
          exp_cmd = cmd_exp_q.pop_front();
          check_eq("sb_cmd", 32'(bus.cmd), 32'(exp_cmd));
        end
      end
      rdy_prev = bus.cmd_rdy;
      if (bus.trmt) begin
        trmt_cnt++;
        if (tx_exp_q.size() == 0) begin
          check_eq("trmt_unexpected", 32'(tx_exp_q.size()), 32'd1);
        end else begin
          exp_tx = tx_exp_q.pop_front();
          check_eq("sb_tx_data", 32'(bus.tx_data), 32'(exp_tx));
        end
      end
      if (bus.resp_sent) sent_cnt++;
    end
  end

  // All driver tasks start and end at a falling edge
  task automatic send_byte(input logic [BYTE_W-1:0] b);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (bus.clr_rx_rdy) begin
        @(negedge clk);
        bus.rx_rdy = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check_eq("rx_accept_bound", 32'(bus.clr_rx_rdy), 32'd1);
    bus.rx_rdy = 1'b0;
  endtask

  task automatic clear_cmd();
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    check_eq("cmd_rdy_cleared", 32'(bus.cmd_rdy), 32'd0);
  endtask

  task automatic request_resp(input logic [BYTE_W-1:0] b);
    bus.send_resp = 1'b1;
    bus.resp_data = b;
    @(negedge clk);
    bus.send_resp = 1'b0;
  endtask

  task automatic pulse_tx_done();
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int unsigned base;
    logic        seen;
    logic [CMD_W-1:0] c;

    bus.rx_rdy      = 1'b0;
    bus.rx_data     = '0;
    bus.tx_done     = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    bus.resp_data   = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_cmd", 32'(bus.cmd), 32'h0);
    check_eq("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    check_eq("rst_trmt", 32'(bus.trmt), 32'd0);
    check_eq("rst_tx_data", 32'(bus.tx_data), 32'h0);
    check_eq("rst_resp_sent", 32'(bus.resp_sent), 32'd0);
    check_eq("rst_clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic three-byte command
    base = clr_cnt;
    send_byte(8'h02);
    send_byte(8'h0D);
    check_eq("rdy_before_third", 32'(bus.cmd_rdy), 32'd0);
    cmd_exp_q.push_back(24'h020D00);
    send_byte(8'h00);
    check_eq("rdy_after_third", 32'(bus.cmd_rdy), 32'd1);
    check_eq("cmd_020d00", 32'(bus.cmd), 32'h020D00);
    check_eq("clr_pulses_3", 32'(clr_cnt - base), 32'd3);

    // Byte held off while a command is pending
    base = clr_cnt;
    seen = 1'b0;
    bus.rx_rdy  = 1'b1;
    bus.rx_data = 8'h07;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.clr_rx_rdy) seen = 1'b1;
      @(negedge clk);
    end
    check_eq("full_no_clr", 32'(seen), 32'd0);
    check_eq("full_clr_count", 32'(clr_cnt - base), 32'd0);
    check_eq("full_cmd_held", 32'(bus.cmd), 32'h020D00);
    bus.clr_cmd_rdy = 1'b1;
    #1;
    check_eq("clear_beats_byte", 32'(bus.clr_rx_rdy), 32'd0);
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    check_eq("rdy_dropped", 32'(bus.cmd_rdy), 32'd0);
    #1;
    check_eq("byte_next_cycle", 32'(bus.clr_rx_rdy), 32'd1);
    @(negedge clk);
    bus.rx_rdy = 1'b0;
    c = bus.cmd;
    check_eq("cmd_hi_07", 32'(c[23:16]), 32'h07);
    check_eq("cmd_lo_kept", 32'(c[15:0]), 32'h0D00);
    send_byte(8'h11);
    cmd_exp_q.push_back(24'h071122);
    send_byte(8'h22);
    check_eq("cmd_071122", 32'(bus.cmd), 32'h071122);
    clear_cmd();

    // Response path, with a request while busy
    base = sent_cnt;
    tx_exp_q.push_back(8'hA5);
    request_resp(8'hA5);
    check_eq("trmt_pulse", 32'(bus.trmt), 32'd1);
    check_eq("tx_data_a5", 32'(bus.tx_data), 32'hA5);
    request_resp(8'hEE);
    check_eq("trmt_one_cycle", 32'(bus.trmt), 32'd0);
    check_eq("busy_ignores_req", 32'(bus.tx_data), 32'hA5);
    repeat (18) @(negedge clk);
    check_eq("no_sent_before_done", 32'(bus.resp_sent), 32'd0);
    pulse_tx_done();
    check_eq("resp_sent_pulse", 32'(bus.resp_sent), 32'd1);
    check_eq("tx_data_stable", 32'(bus.tx_data), 32'hA5);
    @(negedge clk);
    check_eq("resp_sent_one_cycle", 32'(bus.resp_sent), 32'd0);
    @(negedge clk);
    check_eq("sent_count_1", 32'(sent_cnt - base), 32'd1);

    // Command assembly concurrent with a response in flight
    base = sent_cnt;
    tx_exp_q.push_back(8'hEE);
    request_resp(8'hEE);
    fork
      begin
        send_byte(8'h09);
        send_byte(8'h05);
        cmd_exp_q.push_back(24'h090500);
        send_byte(8'h00);
      end
      begin
        repeat (2) @(negedge clk);
        pulse_tx_done();
      end
    join
    check_eq("cmd_090500", 32'(bus.cmd), 32'h090500);
    check_eq("rdy_concurrent", 32'(bus.cmd_rdy), 32'd1);
    repeat (2) @(negedge clk);
    check_eq("sent_concurrent", 32'(sent_cnt - base), 32'd1);
    clear_cmd();

    // Reset in the middle of a command and a transmission
    base = sent_cnt;
    send_byte(8'h33);
    send_byte(8'h44);
    tx_exp_q.push_back(8'h5A);
    request_resp(8'h5A);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_cmd", 32'(bus.cmd), 32'h0);
    check_eq("mid_rst_trmt", 32'(bus.trmt), 32'd0);
    check_eq("mid_rst_tx_data", 32'(bus.tx_data), 32'h0);
    check_eq("mid_rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_tx_done();
    check_eq("no_sent_after_rst", 32'(bus.resp_sent), 32'd0);
    send_byte(8'h12);
    send_byte(8'h34);
    cmd_exp_q.push_back(24'h123456);
    send_byte(8'h56);
    check_eq("cmd_after_rst", 32'(bus.cmd), 32'h123456);
    repeat (2) @(negedge clk);
    check_eq("sent_after_rst", 32'(sent_cnt - base), 32'd0);
    clear_cmd();

    // clr_cmd_rdy while assembling is ignored
    send_byte(8'hAA);
    clear_cmd();
    send_byte(8'hBB);
    cmd_exp_q.push_back(24'hAABBCC);
    send_byte(8'hCC);
    check_eq("cmd_aabbcc", 32'(bus.cmd), 32'hAABBCC);
    clear_cmd();

`ifdef CMD_TIMEOUT_EN
    // Gap reaching the timeout: first byte dropped
    send_byte(8'h04);
    repeat (100) @(negedge clk);
    send_byte(8'h01);
    send_byte(8'h00);
    check_eq("to_two_bytes_only", 32'(bus.cmd_rdy), 32'd0);
    cmd_exp_q.push_back(24'h010080);
    send_byte(8'h80);
    check_eq("to_cmd_010080", 32'(bus.cmd), 32'h010080);
    clear_cmd();
    // Byte arriving on the timeout cycle wins
    send_byte(8'h04);
    repeat (99) @(negedge clk);
    send_byte(8'h01);
    cmd_exp_q.push_back(24'h040100);
    send_byte(8'h00);
    check_eq("to_edge_rdy", 32'(bus.cmd_rdy), 32'd1);
    check_eq("to_edge_cmd", 32'(bus.cmd), 32'h040100);
    clear_cmd();
`else
    // Without timeout a partial command waits indefinitely
    send_byte(8'h04);
    repeat (150) @(negedge clk);
    send_byte(8'h01);
    check_eq("wait_rdy_low", 32'(bus.cmd_rdy), 32'd0);
    cmd_exp_q.push_back(24'h040100);
    send_byte(8'h00);
    check_eq("wait_rdy", 32'(bus.cmd_rdy), 32'd1);
    check_eq("wait_cmd_040100", 32'(bus.cmd), 32'h040100);
    clear_cmd();
`endif

    repeat (3) @(negedge clk);
    check_eq("cmd_queue_drained", 32'(cmd_exp_q.size()), 32'd0);
    check_eq("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_link.md
Name: uart_cmd_link

Overview:
- Byte-level bridge between the UART receiver/transmitter and the command processor.
- Assembles three received bytes, most significant first, into a 24-bit command and raises cmd_rdy.
- Holds the command until the command processor clears it.
- Transmits single-byte responses on send_resp and reports completion on resp_sent.

Parameters:
- TIMEOUT_CYC, 1000000, inter-byte timeout in clk cycles (20 ms at 50 MHz); used only when CMD_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- rx_rdy  input  1  UART receiver has a byte; held high until clr_rx_rdy
- rx_data  input  8  received byte, valid while rx_rdy=1
- clr_rx_rdy  output  1  combinational; high in the cycle a byte is accepted
- trmt  output  1  one-cycle pulse starting a UART transmission
- tx_data  output  8  byte to transmit, stable from the trmt pulse until tx_done
- tx_done  input  1  UART transmitter finished the current byte
- cmd  output  24  assembled command {byte0, byte1, byte2}
- cmd_rdy  output  1  complete command available
- clr_cmd_rdy  input  1  command processor consumed the command
- send_resp  input  1  one-cycle request to transmit resp_data
- resp_data  input  8  response byte, sampled when send_resp=1
- resp_sent  output  1  one-cycle pulse when the response byte is done

Behaviour:
- Single clock domain; all flops reset asynchronously on rst_n low.
- Reset values: cmd=0, cmd_rdy=0, trmt=0, tx_data=0, resp_sent=0, RX state=RX_B2, TX state=TX_IDLE.
- RX FSM states:
  - RX_B2: waits for the high byte. On rx_rdy, accept: cmd[23:16]<=rx_data, go to RX_B1.
  - RX_B1: on rx_rdy, accept: cmd[15:8]<=rx_data, go to RX_B0.
  - RX_B0: on rx_rdy, accept: cmd[7:0]<=rx_data, cmd_rdy<=1, go to RX_FULL. cmd_rdy is high the cycle after the third byte is accepted.
  - RX_FULL: bytes are not accepted. rx_rdy stays pending and clr_rx_rdy=0. On clr_cmd_rdy: cmd_rdy<=0, go to RX_B2.
- Accept condition: rx_rdy=1 and RX state is RX_B2, RX_B1 or RX_B0. clr_rx_rdy=1 in that same cycle only.
- cmd holds its last value after clearing; it changes only when a byte is accepted.
- clr_cmd_rdy outside RX_FULL is ignored.
- Simultaneous clr_cmd_rdy and a pending rx_rdy in RX_FULL: the clear takes effect; the byte is accepted in the following cycle in RX_B2.
- TX FSM states:
  - TX_IDLE: on send_resp, tx_data<=resp_data, trmt<=1 for exactly one cycle (trmt high in the cycle after send_resp), go to TX_BUSY.
  - TX_BUSY: on tx_done, resp_sent<=1 for one cycle, go to TX_IDLE.
- send_resp in TX_BUSY is ignored; tx_data is not disturbed.
- tx_done in TX_IDLE is ignored.
- RX and TX FSMs are independent. Receiving the next command while a response is transmitting is legal.
- Reset mid-command or mid-transmit discards partial bytes and any outstanding response. No resp_sent is issued.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on every accepted byte.
  - It increments while in RX_B1 or RX_B0.
  - When it reaches TIMEOUT_CYC-1, the RX FSM returns to RX_B2 and the partial command is discarded. cmd is left unchanged and cmd_rdy is not asserted.
  - A byte accepted in the same cycle as the timeout wins: the byte is captured and the timeout is cancelled.
- Undefined: no counter; a partial command waits indefinitely.

Decomposition:
- Package uart_cmd_pkg:
  - rx_state_t (RX_B2, RX_B1, RX_B0, RX_FULL)
  - tx_state_t (TX_IDLE, TX_BUSY)
  - CMD_W=24
  - BYTE_W=8
- Natural sub-module resp_tx_seq: the TX FSM plus the tx_data/trmt/resp_sent flops, instantiated once. RX assembly stays in the top.

Test Plan:
- Bytes 0x02, 0x0D, 0x00 with rx_rdy, each held until clr_rx_rdy -> three clr_rx_rdy pulses; cmd=0x020D00 and cmd_rdy=1 the cycle after the third accept.
- With cmd_rdy=1, present 0x07 on rx_rdy for 50 cycles -> clr_rx_rdy stays 0 and cmd is unchanged. Pulse clr_cmd_rdy -> cmd_rdy=0; 0x07 accepted next cycle; cmd[23:16]=0x07.
- send_resp with resp_data=0xA5 -> trmt pulses once next cycle with tx_data=0xA5. Second send_resp (0xEE) while busy is ignored. tx_done after 20 cycles -> one resp_sent pulse; tx_data stays 0xA5.
- Response 0xEE in flight while bytes 0x09, 0x05, 0x00 arrive -> cmd=0x090500 assembled normally; resp_sent follows tx_done independently.
- Assert rst_n low after 2 bytes and during TX_BUSY -> all outputs return to reset values. A fresh 3-byte command assembles correctly.
- CMD_TIMEOUT_EN defined with TIMEOUT_CYC=100: send 0x04, wait 100 cycles, then send 0x01, 0x00, 0x80 -> cmd=0x010080 (first byte discarded). Repeat with a 99-cycle gap -> cmd=0x040100 and cmd_rdy=1 after three bytes.
